wptr_full_gen: RTL and testbench

WPTR_FULL_GEN -- requirements
Module: wptr_full_gen

---
 rtl/wptr_full_gen_if.sv | 34 +++
 rtl/wptr_full_gen.sv | 90 +++++++++
 tb/tb_wptr_full_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wptr_full_gen_if.sv
// Write-side pointer/flag bundle between a FIFO write client and wptr_full_gen.
// Optional almost-full flag present only when WPTR_ALMOST_FULL_EN is defined.
interface wptr_full_gen_if #(
   parameter int unsigned ADDR_SIZE = 4
);
   logic                 winc;
   logic [ADDR_SIZE:0]   rq2_wptr;
   logic [ADDR_SIZE-1:0] waddr;
   logic [ADDR_SIZE:0]   wptr;
   logic                 wfull;
`ifdef WPTR_ALMOST_FULL_EN
   logic                 wafull;

   modport master (
      output winc, rq2_wptr,
      input  waddr, wptr, wfull, wafull
   );

   modport slave (
      input  winc, rq2_wptr,
      output waddr, wptr, wfull, wafull
   );
`else
   modport master (
      output winc, rq2_wptr,
      input  waddr, wptr, wfull
   );

   modport slave (
      input  winc, rq2_wptr,
      output waddr, wptr, wfull
   );
`endif
endinterface

// File: rtl/wptr_full_gen.sv
// Async-FIFO write pointer and full-flag generator.
// Keeps a binary write pointer, publishes it in Gray code for the read domain,
// and raises wfull when the next Gray pointer is one lap ahead of the
// synchronized read pointer.
// Optional feature macro: WPTR_ALMOST_FULL_EN adds the registered wafull flag.
module wptr_full_gen #(
   parameter int unsigned ADDR_SIZE    = 4,
   parameter int unsigned AFULL_MARGIN = 2
) (
   input  logic           clk,
   input  logic           rst,
   wptr_full_gen_if.slave wif
);

   localparam int unsigned DEPTH = 1 << ADDR_SIZE;

   // Elaboration-time guard on the legal parameter ranges.
   if (ADDR_SIZE < 2 || ADDR_SIZE > 12 ||
       AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1 ||
       $bits(wif.wptr) != ADDR_SIZE + 1) begin : g_param_check
      $error("wptr_full_gen: parameter out of range or interface width mismatch");
   end

   logic [ADDR_SIZE:0] wbin;
   logic [ADDR_SIZE:0] wbin_next;
   logic [ADDR_SIZE:0] wgray_next;
   logic [ADDR_SIZE:0] wptr_q;
   logic [ADDR_SIZE:0] full_target;
   logic               wfull_q;
   logic               wfull_next;
   logic               accept;

   // Next binary/Gray pointer and full detection against the next pointer.
   always_comb begin
      accept      = wif.winc & ~wfull_q;
      wbin_next   = wbin + {{ADDR_SIZE{1'b0}}, accept};
      wgray_next  = wbin_next ^ (wbin_next >> 1);
      full_target = {~wif.rq2_wptr[ADDR_SIZE:ADDR_SIZE-1], wif.rq2_wptr[ADDR_SIZE-2:0]};
      wfull_next  = (wgray_next == full_target);
   end

   // Pointer and full-flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbin    <= '0;
         wptr_q  <= '0;
         wfull_q <= 1'b0;
      end else begin
         wbin    <= wbin_next;
         wptr_q  <= wgray_next;
         wfull_q <= wfull_next;
      end
   end

   assign wif.waddr = wbin[ADDR_SIZE-1:0];
   assign wif.wptr  = wptr_q;
   assign wif.wfull = wfull_q;

`ifdef WPTR_ALMOST_FULL_EN
   localparam logic [ADDR_SIZE:0] AFULL_LEVEL = (ADDR_SIZE + 1)'(DEPTH - AFULL_MARGIN);

   logic [ADDR_SIZE:0] rbin;
   logic [ADDR_SIZE:0] occ_next;
   logic               wafull_q;
   logic               wafull_next;

   // Read pointer back to binary; occupancy after this cycle's write.
   // free <= margin is rewritten as occupancy >= DEPTH - margin.
   always_comb begin
      rbin = '0;
      for (int unsigned k = 0; k <= ADDR_SIZE; k++) begin
         rbin[k] = ^(wif.rq2_wptr >> k);
      end
      occ_next    = wbin_next - rbin;
      wafull_next = (occ_next >= AFULL_LEVEL);
   end

   // Almost-full register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wafull_q <= 1'b0;
      end else begin
         wafull_q <= wafull_next;
      end
   end

   assign wif.wafull = wafull_q;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed bench for wptr_full_gen with ADDR_SIZE=4, AFULL_MARGIN=2.
// Almost-full checks are compiled in when WPTR_ALMOST_FULL_EN is defined.
module tb_wptr_full_gen;

   logic clk;
   logic rst;
   int   nchecks;
   int   nerrors;

   wptr_full_gen_if #(.ADDR_SIZE(4)) wif ();

   wptr_full_gen #(
      .ADDR_SIZE   (4),
      .AFULL_MARGIN(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wif(wif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare observed against expected, count and report.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      if (obs !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_waddr"}, 32'(wif.waddr), 32'd0);
      check({tag, "_wptr"},  32'(wif.wptr),  32'd0);
      check({tag, "_wfull"}, 32'(wif.wfull), 32'd0);
`ifdef WPTR_ALMOST_FULL_EN
      check({tag, "_wafull"}, 32'(wif.wafull), 32'd0);
`endif
   endtask

   logic [4:0] prev;

   initial begin
      nchecks      = 0;
      nerrors      = 0;
      rst          = 1'b1;
      wif.winc     = 1'b1;
      wif.rq2_wptr = 5'b10101;

      // Reset with winc held high, rq2_wptr ignored.
      for (int i = 0; i < 2; i++) begin
         tick();
         check_all_zero("reset");
      end

      // Fill from empty: 16 writes against rq2_wptr=0.
      rst          = 1'b0;
      wif.rq2_wptr = 5'b00000;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("fill_waddr", 32'(wif.waddr), 32'(k % 16));
         check("fill_wptr",  32'(wif.wptr),  32'(gray(5'(k))));
         check("fill_wfull", 32'(wif.wfull), (k == 16) ? 32'd1 : 32'd0);
`ifdef WPTR_ALMOST_FULL_EN
         check("fill_wafull", 32'(wif.wafull), (k >= 14) ? 32'd1 : 32'd0);
`endif
      end
      check("full_wptr",  32'(wif.wptr),  32'b11000);
      check("full_waddr", 32'(wif.waddr), 32'd0);

      // Writes while full are ignored.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_wptr",  32'(wif.wptr),  32'b11000);
         check("hold_waddr", 32'(wif.waddr), 32'd0);
         check("hold_wfull", 32'(wif.wfull), 32'd1);
      end

      // Reader frees one slot; same-cycle winc is still gated by wfull.
      wif.rq2_wptr = 5'b00001;
      tick();
      check("free_wfull", 32'(wif.wfull), 32'd0);
      check("free_wptr",  32'(wif.wptr),  32'b11000);
      tick();
      check("refill_wptr",  32'(wif.wptr),  32'b11001);
      check("refill_waddr", 32'(wif.waddr), 32'd1);
      check("refill_wfull", 32'(wif.wfull), 32'd1);
`ifdef WPTR_ALMOST_FULL_EN
      check("refill_wafull", 32'(wif.wafull), 32'd1);
`endif

      // Reset while full with winc high.
      rst = 1'b1;
      tick();
      check_all_zero("rst_full");
      rst = 1'b0;

      // 32 writes with the reader caught up: full lap plus wrap, single-bit steps.
      prev = 5'b00000;
      for (int k = 1; k <= 32; k++) begin
         wif.rq2_wptr = gray(5'(k - 1));
         tick();
         check("lap_wptr",  32'(wif.wptr),  32'(gray(5'(k % 32))));
         check("lap_waddr", 32'(wif.waddr), 32'(k % 16));
         check("lap_step",  32'($countones(prev ^ wif.wptr)), 32'd1);
         check("lap_wfull", 32'(wif.wfull), 32'd0);
`ifdef WPTR_ALMOST_FULL_EN
         check("lap_wafull", 32'(wif.wafull), 32'd0);
`endif
         if (k == 31) begin
            check("wrap_pre_wptr",  32'(wif.wptr),  32'b10000);
            check("wrap_pre_waddr", 32'(wif.waddr), 32'd15);
         end
         prev = wif.wptr;
      end
      check("wrap_wptr",  32'(wif.wptr),  32'b00000);
      check("wrap_waddr", 32'(wif.waddr), 32'd0);

      // Fresh start, 14 writes against rq2_wptr=0, then reset mid-stream.
      wif.winc = 1'b0;
      rst      = 1'b1;
      tick();
      rst          = 1'b0;
      wif.winc     = 1'b1;
      wif.rq2_wptr = 5'b00000;
      for (int k = 1; k <= 14; k++) begin
         tick();
      end
      check("af14_waddr", 32'(wif.waddr), 32'd14);
      check("af14_wptr",  32'(wif.wptr),  32'b01001);
      check("af14_wfull", 32'(wif.wfull), 32'd0);
`ifdef WPTR_ALMOST_FULL_EN
      check("af14_wafull", 32'(wif.wafull), 32'd1);
`endif
      rst = 1'b1;
      tick();
      check_all_zero("rst_mid");
      rst      = 1'b0;
      wif.winc = 1'b1;
      tick();
      check("post_rst_waddr", 32'(wif.waddr), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
